// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_t : transaction sequencer states (IDLE -> ISSUE -> WAIT -> DONE)
//   REQ_FETCH   : requester id of instruction fetch (r0)
//   REQ_LSU     : requester id of the load/store unit (r1)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all requester-side and memory-side signals of mem_port_arbiter.
// Handshake: rN_req is raised with rN_we/rN_addr/rN_wdata stable and held
// until the requester sees the one-cycle rN_gnt pulse (the cycle the access
// is issued to memory); rN_done pulses once when the transaction completes,
// with rN_rdata valid only in that cycle and only for reads. mem_en is a
// one-cycle strobe; mem_rdata must be valid MEM_LAT cycles after it.
//   slave  : arbiter side (consumes requests and mem_rdata)
//   master : requesters + memory model side
// busy is high whenever the arbiter is not idle.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_done;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_done;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_done, r0_rdata,
    output r1_gnt, r1_done, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_done, r0_rdata,
    input  r1_gnt, r1_done, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/arb_pick2.sv
// Combinational two-way request picker.
//   req[1:0] : pending requests (bit index = requester id)
//   prio     : id preferred when both request (round-robin build only)
//   gnt_id   : id of the winner (meaningful only when any=1)
//   any      : at least one request pending
// Policy macro: ARB_ROUND_ROBIN_EN selects round-robin (prio breaks ties);
// otherwise fixed priority with the LSU (r1) always winning.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_id,
  output logic       any
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    any = |req;
    if (req == 2'b11) gnt_id = prio;
    else              gnt_id = req[1] ? REQ_LSU : REQ_FETCH;
  end
`else
  // Fixed priority ignores the preference input.
  logic unused_prio;
  assign unused_prio = prio;

  always_comb begin
    any    = |req;
    gnt_id = req[1] ? REQ_LSU : REQ_FETCH;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between instruction fetch (r0) and the LSU
// (r1), running one transaction at a time: arbitrate in IDLE, strobe the
// memory in ISSUE, wait MEM_LAT cycles in WAIT, report completion in DONE.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_port_arbiter_if.slave (requesters, memory, busy)
//   dbg_state  : current sequencer state
// Parameters: ADDR_W, DATA_W, MEM_LAT (>=1, read latency after mem_en).
// Macro ARB_ROUND_ROBIN_EN: round-robin arbitration (pointer resets to r0);
// undefined: fixed priority, r1 beats r0, no pointer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_port_arbiter_if.slave      bus,
  output arb_state_t             dbg_state
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  // WAIT lasts counter-load + 1 cycles, i.e. exactly MEM_LAT cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;

  logic pick_id, pick_any, pick_prio;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_q, prio_d;
  assign pick_prio = prio_q;
`else
  assign pick_prio = REQ_LSU;
`endif

  arb_pick2 u_pick (
    .req    ({bus.r1_req, bus.r0_req}),
    .prio   (pick_prio),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    rdata0_d = '0;
    rdata1_d = '0;
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    prio_d   = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          // Outputs are registered, so the ISSUE-cycle strobe and grant are
          // computed here on the IDLE->ISSUE transition.
          state_d         = ISSUE;
          owner_d         = pick_id;
          we_d            = pick_id ? bus.r1_we    : bus.r0_we;
          addr_d          = pick_id ? bus.r1_addr  : bus.r0_addr;
          wdata_d         = pick_id ? bus.r1_wdata : bus.r0_wdata;
          gnt_d[pick_id]  = 1'b1;
          mem_en_d        = 1'b1;
          mem_we_d        = we_d;
`ifdef ARB_ROUND_ROBIN_EN
          prio_d          = ~pick_id;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // mem_rdata is valid in this cycle; it goes straight into the
          // registered rdata output presented during DONE.
          state_d         = DONE;
          done_d[owner_q] = 1'b1;
          if (!we_q) begin
            if (owner_q == REQ_LSU) rdata1_d = bus.mem_rdata;
            else                    rdata0_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= REQ_FETCH;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_q   <= REQ_FETCH;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      busy_q   <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      prio_q   <= prio_d;
`endif
    end
  end

  assign bus.r0_gnt    = gnt_q[0];
  assign bus.r1_gnt    = gnt_q[1];
  assign bus.r0_done   = done_q[0];
  assign bus.r1_done   = done_q[1];
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state_q;

endmodule
